matmul_mem_sequencer: RTL and testbench

- Master that drives main memory's memread/memwrite/address/data_in port and consumes its combinational data_out.
- Computes C = A x B for NxN unsigned 32-bit matrices, all stored row-major, one word per element, 4-byte stride.
- Reads A from A_BASE and B from B_BASE; writes C to C_BASE.
- Sits directly upstream of main memory and replaces the hand-coded load/store loop that the core would otherwise run.

---
 rtl/matmul_mem_sequencer.sv | 173 +++++++++++++++++
 tb/tb_matmul_mem_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_mem_sequencer.sv
// Memory-mastering sequencer computing C = A x B for NxN unsigned matrices stored row-major.
// Define MATMUL_OVF_EN to add the sticky ovf output (product high-half or accumulate carry).
module matmul_mem_sequencer #(
    parameter int unsigned         N      = 3,
    parameter int unsigned         ADDR_W = 17,
    parameter int unsigned         DATA_W = 32,
    parameter logic [ADDR_W-1:0]   A_BASE = 'h00200,
    parameter logic [ADDR_W-1:0]   B_BASE = 'h00300,
    parameter logic [ADDR_W-1:0]   C_BASE = 'h00100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
`ifdef MATMUL_OVF_EN
    output logic              ovf,
`endif
    input  logic [DATA_W-1:0] data_out
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StWrC,
        StDone
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     i_q, j_q, k_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [31:0]       a_idx, b_idx, c_idx;

`ifdef MATMUL_OVF_EN
    logic              ovf_q;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W:0]     acc_sum;
    logic                ovf_hit;

    always_comb begin
        prod    = (2*DATA_W)'(a_q) * (2*DATA_W)'(data_out);
        acc_sum = {1'b0, acc_q} + {1'b0, prod[DATA_W-1:0]};
        acc_d   = acc_sum[DATA_W-1:0];
        ovf_hit = (prod[2*DATA_W-1:DATA_W] != '0) || acc_sum[DATA_W];
    end

    assign ovf = ovf_q;
`else
    // Wrapping multiply-accumulate; only the low word of the product matters.
    always_comb begin
        acc_d = acc_q + (a_q * data_out);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            acc_q   <= '0;
`ifdef MATMUL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        acc_q   <= '0;
`ifdef MATMUL_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                        state_q <= StRdA;
                    end
                end
                StRdA: begin
                    a_q     <= data_out;
                    state_q <= StRdB;
                end
                StRdB: begin
                    acc_q <= acc_d;
`ifdef MATMUL_OVF_EN
                    if (ovf_hit) begin
                        ovf_q <= 1'b1;
                    end
`endif
                    if (k_q == LAST) begin
                        k_q     <= '0;
                        state_q <= StWrC;
                    end else begin
                        k_q     <= k_q + 1'b1;
                        state_q <= StRdA;
                    end
                end
                StWrC: begin
                    acc_q <= '0;
                    if (j_q == LAST) begin
                        j_q <= '0;
                        i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                    if ((i_q == LAST) && (j_q == LAST)) begin
                        state_q <= StDone;
                    end else begin
                        state_q <= StRdA;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        a_idx = 32'(i_q) * N + 32'(k_q);
        b_idx = 32'(k_q) * N + 32'(j_q);
        c_idx = 32'(i_q) * N + 32'(j_q);
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        address  = '0;
        data_in  = '0;
        unique case (state_q)
            StIdle: begin
            end
            StRdA: begin
                busy    = 1'b1;
                memread = 1'b1;
                address = A_BASE + ADDR_W'(a_idx << 2);
            end
            StRdB: begin
                busy    = 1'b1;
                memread = 1'b1;
                address = B_BASE + ADDR_W'(b_idx << 2);
            end
            StWrC: begin
                busy     = 1'b1;
                memwrite = 1'b1;
                address  = C_BASE + ADDR_W'(c_idx << 2);
                data_in  = acc_q;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_matmul_mem_sequencer.sv
// Self-checking bench: word-addressed memory model plus a loop-based reference for C and ovf.
module tb_matmul_mem_sequencer;

    localparam int N      = 3;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;
    localparam int ABASE  = 'h200;
    localparam int BBASE  = 'h300;
    localparam int CBASE  = 'h100;
    localparam int NCYC   = N * N * (2 * N + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, memread, memwrite;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in, data_out;
    logic              ovf;

    logic [31:0] mem [0:(1 << (ADDR_W - 2)) - 1];

    logic [31:0] am [N*N];
    logic [31:0] bm [N*N];
    logic [31:0] cm [N*N];
    bit          ovf_ref;
    bit          ek_rd [NCYC];
    bit          ek_wr [NCYC];
    int          ea    [NCYC];
    logic [31:0] ed    [NCYC];

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    assign data_out = memread ? mem[address[ADDR_W-1:2]] : '0;

    matmul_mem_sequencer #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .A_BASE (17'(ABASE)),
        .B_BASE (17'(BBASE)),
        .C_BASE (17'(CBASE))
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .memread  (memread),
        .memwrite (memwrite),
        .address  (address),
        .data_in  (data_in),
`ifdef MATMUL_OVF_EN
        .ovf      (ovf),
`endif
        .data_out (data_out)
    );

`ifndef MATMUL_OVF_EN
    assign ovf = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory commits a pending write at the edge; outputs are sampled 1 time unit later.
    task automatic tick();
        if (memwrite === 1'b1) mem[address[ADDR_W-1:2]] = data_in;
        @(posedge clk);
        #1;
        check("rd_wr_exclusive", 64'(memread && memwrite), 64'd0);
        check("data_in_zero_no_write", (memwrite === 1'b1) ? 64'd0 : 64'(data_in), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_memread"}, 64'(memread), 64'd0);
        check({tag, "_memwrite"}, 64'(memwrite), 64'd0);
        check({tag, "_address"}, 64'(address), 64'd0);
        check({tag, "_data_in"}, 64'(data_in), 64'd0);
    endtask

    // Reference: expected access sequence, C and overflow flag from the algorithm's definition.
    task automatic build_ref();
        int n;
        logic [31:0] acc;
        logic [63:0] p;
        logic [32:0] s;
        n = 0;
        ovf_ref = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 32'd0;
                for (int k = 0; k < N; k++) begin
                    ek_rd[n] = 1'b1; ek_wr[n] = 1'b0; ea[n] = ABASE + 4 * (i * N + k); ed[n] = 0;
                    n++;
                    ek_rd[n] = 1'b1; ek_wr[n] = 1'b0; ea[n] = BBASE + 4 * (k * N + j); ed[n] = 0;
                    n++;
                    p = 64'(am[i*N+k]) * 64'(bm[k*N+j]);
                    if (p[63:32] != 32'd0) ovf_ref = 1'b1;
                    s = 33'(acc) + 33'(p[31:0]);
                    if (s[32]) ovf_ref = 1'b1;
                    acc = s[31:0];
                end
                ek_rd[n] = 1'b0; ek_wr[n] = 1'b1; ea[n] = CBASE + 4 * (i * N + j); ed[n] = acc;
                cm[i*N+j] = acc;
                n++;
            end
        end
        for (int e = 0; e < N * N; e++) begin
            mem[ABASE/4 + e] = am[e];
            mem[BBASE/4 + e] = bm[e];
            mem[CBASE/4 + e] = 32'hDEADBEEF;
        end
    endtask

    task automatic run(input string tag, input bit ignore_start, input int rst_at);
        int nwr;
        nwr = 0;
        build_ref();
        check_idle({tag, "_pre"});
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            check($sformatf("%s_c%0d_busy", tag, c), 64'(busy), 64'd1);
            check($sformatf("%s_c%0d_done", tag, c), 64'(done), 64'd0);
            check($sformatf("%s_c%0d_memread", tag, c), 64'(memread), 64'(ek_rd[c]));
            check($sformatf("%s_c%0d_memwrite", tag, c), 64'(memwrite), 64'(ek_wr[c]));
            check($sformatf("%s_c%0d_address", tag, c), 64'(address), 64'(ea[c]));
            check($sformatf("%s_c%0d_data_in", tag, c), 64'(data_in), 64'(ed[c]));
            if (memwrite === 1'b1) nwr++;
            if (c == rst_at) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                check_idle({tag, "_after_rst"});
                check({tag, "_ovf_after_rst"}, 64'(ovf), 64'd0);
                for (int w = 0; w < 2 * NCYC; w++) begin
                    tick();
                    check({tag, "_no_done_after_rst"}, 64'(done), 64'd0);
                    check({tag, "_no_access_after_rst"}, 64'(memread || memwrite), 64'd0);
                end
                return;
            end
            start = ignore_start && (c == 9);
            tick();
        end
        start = 1'b0;
        // Done cycle ends on the 64th edge counted from the start-sampling edge.
        check({tag, "_done_pulse"}, 64'(done), 64'd1);
        check({tag, "_done_busy"}, 64'(busy), 64'd0);
        check({tag, "_done_strobes"}, 64'(memread || memwrite), 64'd0);
`ifdef MATMUL_OVF_EN
        check({tag, "_ovf_at_done"}, 64'(ovf), 64'(ovf_ref));
`endif
        check({tag, "_write_count"}, 64'(nwr), 64'(N * N));
        tick();
        check_idle({tag, "_post"});
`ifdef MATMUL_OVF_EN
        check({tag, "_ovf_held"}, 64'(ovf), 64'(ovf_ref));
`endif
        for (int e = 0; e < N * N; e++) begin
            check($sformatf("%s_C%0d", tag, e), 64'(mem[CBASE/4 + e]), 64'(cm[e]));
        end
    endtask

    task automatic set_identity_b();
        for (int e = 0; e < N * N; e++) bm[e] = (e / N == e % N) ? 32'd1 : 32'd0;
    endtask

    initial begin
        for (int w = 0; w < (1 << (ADDR_W - 2)); w++) mem[w] = 32'd0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_idle("reset");
        check("reset_ovf", 64'(ovf), 64'd0);

        for (int e = 0; e < N * N; e++) am[e] = 32'(e + 1);
        set_identity_b();
        run("identity", 1'b0, -1);

        for (int e = 0; e < N * N; e++) begin
            am[e] = 32'd2;
            bm[e] = 32'd3;
        end
        run("constant", 1'b0, -1);

        for (int e = 0; e < N * N; e++) am[e] = 32'($urandom_range(0, 100));
        am[0] = 32'hFFFF_FFFF;
        set_identity_b();
        bm[0] = 32'd2;
        run("overflow", 1'b0, -1);

        for (int e = 0; e < N * N; e++) am[e] = 32'(e + 1);
        set_identity_b();
        run("identity_clear", 1'b0, -1);

        for (int e = 0; e < N * N; e++) begin
            am[e] = $urandom;
            bm[e] = $urandom;
        end
        run("rand_ignore", 1'b1, -1);

        for (int e = 0; e < N * N; e++) begin
            am[e] = $urandom;
            bm[e] = $urandom;
        end
        run("rand_reset", 1'b0, 19);

        for (int e = 0; e < N * N; e++) begin
            am[e] = $urandom_range(0, 65535);
            bm[e] = $urandom_range(0, 65535);
        end
        run("rand_fresh", 1'b0, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
